// File: rtl/rv32_decode_exec_if.sv
// Decode/execute slice bus: instruction and operands in,
// decode fields, controls and EX/MEM registered bundle out.
interface rv32_decode_exec_if;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [6:0]  op;
  logic [2:0]  func;
  logic [6:0]  op_2;
  logic [11:0] imm;
  logic [31:0] ext_imm;
  logic        lw_en;
  logic        sw_en;
  logic        wr_en;
  logic        sub_en;
  logic        offset_en;
  logic        mux_sel;
  logic [31:0] alu_result_q;
  logic [31:0] store_data_q;
  logic [4:0]  rd_q;
  logic        wr_en_q;
  logic        lw_en_q;
  logic        sw_en_q;

  modport master (
    output instr, rs1_data, rs2_data,
    input  rs1, rs2, rd, op, func, op_2,
    input  imm, ext_imm,
    input  lw_en, sw_en, wr_en,
    input  sub_en, offset_en, mux_sel,
    input  alu_result_q, store_data_q,
    input  rd_q, wr_en_q, lw_en_q, sw_en_q
  );

  modport slave (
    input  instr, rs1_data, rs2_data,
    output rs1, rs2, rd, op, func, op_2,
    output imm, ext_imm,
    output lw_en, sw_en, wr_en,
    output sub_en, offset_en, mux_sel,
    output alu_result_q, store_data_q,
    output rd_q, wr_en_q, lw_en_q, sw_en_q
  );
endinterface

// File: rtl/rv32_decode_exec.sv
// RV32I decode, control and ALU slice.
// Only state is the EX/MEM register bundle.
module rv32_decode_exec (
  input logic               clk,
  input logic               rst,
  rv32_decode_exec_if.slave bus
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  logic [31:0] ins;
  logic [6:0]  op;
  logic [2:0]  func;
  logic [6:0]  op_2;
  logic [4:0]  rd;
  logic        is_r, is_i, is_lw, is_sw, is_b;
  logic [11:0] imm;
  logic [31:0] ext_imm;
  logic        wr_raw, sub_en, mux_sel;
  logic        wr_en;
  logic [31:0] a, b;
  logic [31:0] alu_result;

  assign ins  = bus.instr;
  assign op   = ins[6:0];
  assign func = ins[14:12];
  assign op_2 = ins[31:25];
  assign rd   = ins[11:7];

  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  assign is_b  = (op == OP_B);

  // Immediate selection by instruction format
  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_i, is_lw: imm = ins[31:20];
      is_sw: imm = {ins[31:25], ins[11:7]};
      is_b: imm = {ins[31], ins[7],
                   ins[30:25], ins[11:8]};
      default: ;
    endcase
  end

  assign ext_imm = {{20{imm[11]}}, imm};

  assign wr_raw  = is_r | is_i | is_lw;
  assign wr_en   = wr_raw & (rd != 5'd0);
  assign sub_en  = is_r & (func == 3'b000)
                 & op_2[5];
  assign mux_sel = is_i | is_lw | is_sw;

  assign a = bus.rs1_data;
  assign b = mux_sel ? ext_imm : bus.rs2_data;

  // ALU: arithmetic/logic for R/I, address for LW/SW
  always_comb begin
    alu_result = '0;
    unique case (1'b1)
      is_r, is_i: begin
        unique case (func)
          3'b000: alu_result = sub_en ? a - b
                                      : a + b;
          3'b001: alu_result = a << b[4:0];
          3'b010: alu_result =
            {31'd0, $signed(a) < $signed(b)};
          3'b011: alu_result = {31'd0, a < b};
          3'b100: alu_result = a ^ b;
          3'b101: alu_result = op_2[5]
            ? 32'($signed(a) >>> b[4:0])
            : a >> b[4:0];
          3'b110: alu_result = a | b;
          3'b111: alu_result = a & b;
          default: ;
        endcase
      end
      is_lw, is_sw: alu_result = a + ext_imm;
      default: ;
    endcase
  end

  assign bus.rs1       = ins[19:15];
  assign bus.rs2       = ins[24:20];
  assign bus.rd        = rd;
  assign bus.op        = op;
  assign bus.func      = func;
  assign bus.op_2      = op_2;
  assign bus.imm       = imm;
  assign bus.ext_imm   = ext_imm;
  assign bus.lw_en     = is_lw;
  assign bus.sw_en     = is_sw;
  assign bus.wr_en     = wr_en;
  assign bus.sub_en    = sub_en;
  assign bus.offset_en = is_b;
  assign bus.mux_sel   = mux_sel;

  // EX/MEM register; reset drops in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_result_q <= '0;
      bus.store_data_q <= '0;
      bus.rd_q         <= '0;
      bus.wr_en_q      <= 1'b0;
      bus.lw_en_q      <= 1'b0;
      bus.sw_en_q      <= 1'b0;
    end else begin
      bus.alu_result_q <= alu_result;
      bus.store_data_q <= bus.rs2_data;
      bus.rd_q         <= rd;
      bus.wr_en_q      <= wr_en;
      bus.lw_en_q      <= is_lw;
      bus.sw_en_q      <= is_sw;
    end
  end

endmodule

// File: tb/tb_rv32_decode_exec.sv
// Directed bench for rv32_decode_exec with
// hand-computed expected values.
module tb_rv32_decode_exec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  rv32_decode_exec_if bus ();

  rv32_decode_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.instr    = i;
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q_zero(input string tag);
    check({tag, "_res"}, bus.alu_result_q, 0);
    check({tag, "_sd"}, bus.store_data_q, 0);
    check({tag, "_rd"}, 32'(bus.rd_q), 0);
    check({tag, "_wr"}, 32'(bus.wr_en_q), 0);
    check({tag, "_lw"}, 32'(bus.lw_en_q), 0);
    check({tag, "_sw"}, 32'(bus.sw_en_q), 0);
  endtask

  initial begin
    drive(32'h002081B3, 32'd5, 32'd7);
    tick();
    check_q_zero("rst");
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'd5, 32'd7);
    check("add_rs1", 32'(bus.rs1), 1);
    check("add_rs2", 32'(bus.rs2), 2);
    check("add_rd", 32'(bus.rd), 3);
    check("add_op", 32'(bus.op), 32'h33);
    check("add_wr", 32'(bus.wr_en), 1);
    check("add_sub", 32'(bus.sub_en), 0);
    check("add_mux", 32'(bus.mux_sel), 0);
    tick();
    check("add_res", bus.alu_result_q, 12);
    check("add_rdq", 32'(bus.rd_q), 3);
    check("add_wrq", 32'(bus.wr_en_q), 1);

    // SUB x3,x1,x2
    drive(32'h402081B3, 32'd5, 32'd7);
    check("sub_sub", 32'(bus.sub_en), 1);
    check("sub_op2", 32'(bus.op_2), 32'h20);
    tick();
    check("sub_res", bus.alu_result_q,
          32'hFFFFFFFE);

    // ADDI x5,x0,-1
    drive(32'hFFF00293, 32'd0, 32'd9);
    check("addi_imm", 32'(bus.imm), 32'hFFF);
    check("addi_ext", bus.ext_imm, 32'hFFFFFFFF);
    check("addi_mux", 32'(bus.mux_sel), 1);
    check("addi_sub", 32'(bus.sub_en), 0);
    tick();
    check("addi_res", bus.alu_result_q,
          32'hFFFFFFFF);
    check("addi_rdq", 32'(bus.rd_q), 5);

    // SRAI / SRLI x6,x1,4
    drive(32'h4040D313, 32'h80000000, 32'd0);
    tick();
    check("srai_res", bus.alu_result_q,
          32'hF8000000);
    drive(32'h0040D313, 32'h80000000, 32'd0);
    tick();
    check("srli_res", bus.alu_result_q,
          32'h08000000);

    // R-type func coverage, rs1=-1 rs2=1
    drive(32'h0020A1B3, 32'hFFFFFFFF, 32'd1);
    tick();
    check("slt_res", bus.alu_result_q, 1);
    drive(32'h0020B1B3, 32'hFFFFFFFF, 32'd1);
    tick();
    check("sltu_res", bus.alu_result_q, 0);
    drive(32'h002091B3, 32'h0000000F, 32'd4);
    tick();
    check("sll_res", bus.alu_result_q, 32'hF0);
    drive(32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    check("xor_res", bus.alu_result_q,
          32'h0FF00FF0);
    drive(32'h0020E1B3, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    check("or_res", bus.alu_result_q,
          32'hFFF0FFF0);
    drive(32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    check("and_res", bus.alu_result_q,
          32'hF000F000);

    // LW x7,8(x2)
    drive(32'h00812383, 32'h100, 32'd0);
    check("lw_en", 32'(bus.lw_en), 1);
    check("lw_func", 32'(bus.func), 2);
    tick();
    check("lw_res", bus.alu_result_q, 32'h108);
    check("lw_lwq", 32'(bus.lw_en_q), 1);
    check("lw_wrq", 32'(bus.wr_en_q), 1);
    check("lw_rdq", 32'(bus.rd_q), 7);

    // SW x2,12(x1)
    drive(32'h0020A623, 32'h40, 32'hDEADBEEF);
    check("sw_imm", 32'(bus.imm), 32'h00C);
    check("sw_wr", 32'(bus.wr_en), 0);
    tick();
    check("sw_res", bus.alu_result_q, 32'h4C);
    check("sw_sd", bus.store_data_q, 32'hDEADBEEF);
    check("sw_swq", 32'(bus.sw_en_q), 1);
    check("sw_wrq", 32'(bus.wr_en_q), 0);
    check("sw_lwq", 32'(bus.lw_en_q), 0);

    // BEQ x1,x2,+8
    drive(32'h00208463, 32'd3, 32'd3);
    check("beq_imm", 32'(bus.imm), 32'h004);
    check("beq_off", 32'(bus.offset_en), 1);
    check("beq_mux", 32'(bus.mux_sel), 0);
    tick();
    check("beq_res", bus.alu_result_q, 0);
    check("beq_wrq", 32'(bus.wr_en_q), 0);

    // ADD in flight when reset hits
    drive(32'h002081B3, 32'd5, 32'd7);
    rst = 1'b1;
    check("rstc_wr", 32'(bus.wr_en), 1);
    tick();
    check_q_zero("midrst");
    rst = 1'b0;

    // NOP writes nothing
    drive(32'h00000013, 32'd0, 32'd0);
    check("nop_wr", 32'(bus.wr_en), 0);
    check("nop_mux", 32'(bus.mux_sel), 1);
    tick();
    check("nop_wrq", 32'(bus.wr_en_q), 0);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
